// File: rtl/mfp_ahb_mst_pkg.sv
// Shared AHB-Lite encodings for the image-processing bus initiator.
package mfp_ahb_mst_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_ERROR   = 1'b1;
endpackage

// File: rtl/mfp_ahb_mst_if.sv
// AHB-Lite bus plus command / write-stream / read-stream handshakes of mfp_ahb_mst.
interface mfp_ahb_mst_if #(parameter int LEN_W = 8) ();
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [2:0]       HBURST;
  logic [31:0]      HWDATA;
  logic [31:0]      HRDATA;
  logic             HREADY;
  logic             HRESP;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      wr_data;
  logic             rd_valid;
  logic [31:0]      rd_data;
  logic             done;
  logic             err;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP,
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data, done, err
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP,
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data, done, err
  );
endinterface

// File: rtl/mfp_ahb_mst.sv
// AHB-Lite initiator: one multi-beat command at a time, pipelined NONSEQ word beats.
// Define MFP_AHB_MST_WAITCNT_EN to add the wait_cnt data-phase stall counter port.
module mfp_ahb_mst
  import mfp_ahb_mst_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic          HCLK,
  input  logic          HRESET,
  mfp_ahb_mst_if.master bus
`ifdef MFP_AHB_MST_WAITCNT_EN
  , output logic [15:0] wait_cnt
`endif
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d, haddr_q, haddr_d;
  logic [31:0]      hwdata_q, hwdata_d, rdata_q, rdata_d;
  logic [LEN_W-1:0] left_q, left_d, dleft_q, dleft_d;
  logic             wr_q, wr_d, hwr_q, hwr_d, dp_q, dp_d, epend_q, epend_d;
  logic             rdv_q, rdv_d, done_q, done_d, err_q, err_d;
  logic             issue, dp_err, dp_ok;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    left_d   = left_q;
    dleft_d  = dleft_q;
    wr_d     = wr_q;
    hwr_d    = hwr_q;
    dp_d     = dp_q;
    epend_d  = epend_q;
    err_d    = err_q;
    rdv_d    = 1'b0;
    done_d   = 1'b0;
    dp_err   = dp_q && (bus.HRESP == HRESP_ERROR);
    dp_ok    = dp_q && bus.HREADY && !dp_err;
    // Address phases are only offered while HREADY=1, so each one is accepted on the spot.
    issue    = (state_q == RUN) && bus.HREADY && (left_q != '0) && !epend_q && !dp_err &&
               (!wr_q || bus.wr_valid);
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = {bus.cmd_addr[31:2], 2'b00};
          left_d  = bus.cmd_len;
          dleft_d = bus.cmd_len;
          wr_d    = bus.cmd_write;
          err_d   = 1'b0;
          epend_d = 1'b0;
          if (bus.cmd_len == '0) done_d  = 1'b1;
          else                   state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d  = addr_q + 32'd4;
          left_d  = left_q - LEN_W'(1);
          haddr_d = addr_q;
          hwr_d   = wr_q;
          if (wr_q) hwdata_d = bus.wr_data;
        end
        if (bus.HREADY) dp_d = issue;
        // First cycle of a two-cycle ERROR response: block any further address phase.
        if (dp_err && !bus.HREADY) epend_d = 1'b1;
        if (dp_ok) begin
          dleft_d = dleft_q - LEN_W'(1);
          if (!wr_q) begin
            rdv_d   = 1'b1;
            rdata_d = bus.HRDATA;
          end
          if (dleft_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        if (dp_err && bus.HREADY) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          dp_d    = 1'b0;
          epend_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      left_q   <= '0;
      dleft_q  <= '0;
      wr_q     <= 1'b0;
      hwr_q    <= 1'b0;
      dp_q     <= 1'b0;
      epend_q  <= 1'b0;
      rdv_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      left_q   <= left_d;
      dleft_q  <= dleft_d;
      wr_q     <= wr_d;
      hwr_q    <= hwr_d;
      dp_q     <= dp_d;
      epend_q  <= epend_d;
      rdv_q    <= rdv_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef MFP_AHB_MST_WAITCNT_EN
  logic [15:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == IDLE && bus.cmd_valid)                         wcnt_d = '0;
    else if (state_q == RUN && dp_q && !bus.HREADY && wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end

  assign wait_cnt = wcnt_q;
`endif

  assign bus.HTRANS    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = issue ? addr_q : haddr_q;
  assign bus.HWRITE    = issue ? wr_q : hwr_q;
  assign bus.HSIZE     = HSIZE_WORD;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HWDATA    = hwdata_q;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wr_ready  = issue && wr_q;
  assign bus.rd_valid  = rdv_q;
  assign bus.rd_data   = rdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mfp_ahb_mst.sv
// Bench for mfp_ahb_mst: command table + scripted AHB slave + address/data scoreboards.
module tb_mfp_ahb_mst;
  import mfp_ahb_mst_pkg::*;
  localparam int LEN_W = 8;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  mfp_ahb_mst_if #(.LEN_W(LEN_W)) bus ();

`ifdef MFP_AHB_MST_WAITCNT_EN
  logic [15:0] wait_cnt;
  mfp_ahb_mst #(.LEN_W(LEN_W)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus), .wait_cnt(wait_cnt));
`else
  mfp_ahb_mst #(.LEN_W(LEN_W)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    int          len;
    int          wait_beat;
    int          nwait;
    int          err_beat;
    int          rst_beat;
    bit          gap;
    int          exp_issue;
    int          exp_wrr;
    int          exp_rd;
    int          exp_done;
    int          exp_err;
    int          exp_wait;
  } vec_t;

  localparam int NV = 11;
  vec_t vt[NV];
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] aq[$];
  logic [31:0] rq[$];
  logic [31:0] wq[$];

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input int len,
                              input int wb, input int nw, input int eb, input int rb, input bit gap,
                              input int ei, input int ew, input int er, input int ed,
                              input int ee, input int ewt);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.wait_beat = wb; v.nwait = nw;
    v.err_beat = eb; v.rst_beat = rb; v.gap = gap;
    v.exp_issue = ei; v.exp_wrr = ew; v.exp_rd = er; v.exp_done = ed;
    v.exp_err = ee; v.exp_wait = ewt;
    return v;
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h1000_0004) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_1234);
  endfunction

  function automatic logic [31:0] wdat(input int ri, input int i);
    return 32'hC0DE_0000 + 32'(ri * 256 + i);
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got 0x%08h, want 0x%08h", nm, row, act, exp);
    end
  endtask

  task automatic missing(input string nm, input int row, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s (row %0d): got 0x%08h, want nothing", nm, row, act);
  endtask

  task automatic run_vec(input int ri);
    vec_t v;
    logic [31:0] base, sl_addr, prev_haddr;
    logic [1:0]  prev_htrans;
    int first_ns, last_ns, last_end, done_cyc, last_rdv, rst_cyc;
    int n_ns, n_wrr, n_rdv, n_done, wd_idx, beat_ctr, sl_beat, sl_w, sl_e, post;
    bit sl_dp, sl_wr, fin, ns, prev_stall;
    v = vt[ri];
    base = {v.addr[31:2], 2'b00};
    first_ns = -1; last_ns = -1; last_end = -1; done_cyc = -1; last_rdv = -1; rst_cyc = -1;
    n_ns = 0; n_wrr = 0; n_rdv = 0; n_done = 0; wd_idx = 0; beat_ctr = 0;
    sl_beat = -1; sl_w = 0; sl_e = 0; post = 0;
    sl_dp = 0; sl_wr = 0; fin = 0; prev_stall = 0; sl_addr = '0; prev_haddr = '0;
    prev_htrans = HTRANS_IDLE;
    aq.delete(); rq.delete(); wq.delete();
    for (int i = 0; i < v.exp_issue; i++) begin
      aq.push_back(base + 32'(4 * i));
      if (v.wr) wq.push_back(wdat(ri, i));
    end
    for (int i = 0; i < v.exp_rd; i++) rq.push_back(mem(base + 32'(4 * i)));

    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(posedge HCLK); #1;
      bus.cmd_valid = (cyc == 0);
      bus.cmd_write = v.wr;
      bus.cmd_addr  = v.addr;
      bus.cmd_len   = LEN_W'(v.len);
      bus.wr_valid  = !(v.gap && (cyc % 3 == 1));
      bus.wr_data   = wdat(ri, wd_idx);
      HRESET        = 1'b0;
      bus.HREADY    = 1'b1;
      bus.HRESP     = 1'b0;
      bus.HRDATA    = mem(sl_addr);
      if (sl_dp) begin
        if (sl_beat == v.err_beat) begin
          bus.HRESP  = 1'b1;
          bus.HREADY = (sl_e != 0);
        end else if (sl_beat == v.wait_beat && sl_w < v.nwait) begin
          bus.HREADY = 1'b0;
        end
        if (sl_beat == v.rst_beat && rst_cyc < 0) begin
          HRESET  = 1'b1;
          rst_cyc = cyc;
        end
      end

      @(negedge HCLK);
      ns = (bus.HTRANS == HTRANS_NONSEQ);
      if (cyc == 0) chk("cmd_ready_idle", ri, 32'(bus.cmd_ready), 32'd1);
      if (!bus.HREADY && prev_stall) begin
        chk("haddr_hold", ri, bus.HADDR, prev_haddr);
        chk("htrans_hold", ri, 32'(bus.HTRANS), 32'(prev_htrans));
      end
      prev_stall  = !bus.HREADY;
      prev_haddr  = bus.HADDR;
      prev_htrans = bus.HTRANS;
      if (sl_dp && bus.HREADY) begin
        last_end = cyc;
        if (sl_wr) begin
          if (wq.size() == 0) missing("hwdata_extra", ri, bus.HWDATA);
          else                chk("hwdata", ri, bus.HWDATA, wq.pop_front());
        end
        if (bus.HRESP) chk("htrans_idle_err2", ri, 32'(bus.HTRANS), 32'(HTRANS_IDLE));
      end
      if (ns) begin
        n_ns++;
        if (first_ns < 0) first_ns = cyc;
        last_ns = cyc;
        if (aq.size() == 0) missing("nonseq_extra", ri, bus.HADDR);
        else                chk("haddr", ri, bus.HADDR, aq.pop_front());
        chk("hwrite", ri, 32'(bus.HWRITE), 32'(v.wr));
      end
      if (bus.wr_ready) begin
        n_wrr++;
        wd_idx++;
      end
      if (bus.rd_valid) begin
        n_rdv++;
        last_rdv = cyc;
        if (rq.size() == 0) missing("rd_valid_extra", ri, bus.rd_data);
        else                chk("rd_data", ri, bus.rd_data, rq.pop_front());
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
        chk("cmd_ready_at_done", ri, 32'(bus.cmd_ready), 32'd1);
        chk("err_at_done", ri, 32'(bus.err), 32'(v.exp_err));
      end
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        chk("rst_htrans", ri, 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk("rst_haddr", ri, bus.HADDR, 32'h0);
        chk("rst_hwdata", ri, bus.HWDATA, 32'h0);
        chk("rst_cmd_ready", ri, 32'(bus.cmd_ready), 32'd1);
        chk("rst_rd_valid", ri, 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", ri, bus.rd_data, 32'h0);
        chk("rst_err", ri, 32'(bus.err), 32'd0);
      end
      if (bus.HREADY) begin
        sl_dp = ns;
        sl_wr = bus.HWRITE;
        if (ns) begin
          sl_beat = beat_ctr;
          beat_ctr++;
          sl_addr = bus.HADDR;
          sl_w = 0;
          sl_e = 0;
        end
      end else if (sl_dp) begin
        if (bus.HRESP) sl_e++;
        else           sl_w++;
      end
      if (n_done > 0 || (rst_cyc >= 0 && cyc > rst_cyc)) post++;
      if (post >= 4) fin = 1;
    end

    if (!fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout (row %0d): got no completion, want done within 300 cycles", ri);
    end
    chk("nonseq_count", ri, 32'(n_ns), 32'(v.exp_issue));
    chk("wr_ready_count", ri, 32'(n_wrr), 32'(v.exp_wrr));
    chk("rd_valid_count", ri, 32'(n_rdv), 32'(v.exp_rd));
    chk("done_count", ri, 32'(n_done), 32'(v.exp_done));
    chk("addr_left", ri, 32'(aq.size()), 32'd0);
    chk("rdata_left", ri, 32'(rq.size()), 32'd0);
    chk("wdata_left", ri, 32'(wq.size()), 32'd0);
    if (v.rst_beat < 0) begin
      if (v.len == 0) chk("done_latency_len0", ri, 32'(done_cyc), 32'd1);
      else            chk("done_latency", ri, 32'(done_cyc), 32'(last_end + 1));
      if (v.len > 0 && !v.gap) chk("first_nonseq", ri, 32'(first_ns), 32'd1);
      if (!v.wr && v.err_beat < 0 && v.len > 0) chk("rd_with_done", ri, 32'(last_rdv), 32'(done_cyc));
      if (v.len > 0 && !v.gap && v.err_beat < 0 && v.nwait == 0)
        chk("back_to_back", ri, 32'(last_ns - first_ns), 32'(v.len - 1));
`ifdef MFP_AHB_MST_WAITCNT_EN
      chk("wait_cnt", ri, 32'(wait_cnt), 32'(v.exp_wait));
`endif
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.HRDATA    = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;

    //          wr    addr          len wb nw  eb  rb gap  iss wrr rd dn er wt
    vt[0]  = mk(1'b0, 32'h1000_0004, 1, -1, 0, -1, -1, 0,  1, 0, 1, 1, 0, 0);
    vt[1]  = mk(1'b1, 32'h0000_0010, 4, -1, 0, -1, -1, 0,  4, 4, 0, 1, 0, 0);
    vt[2]  = mk(1'b0, 32'h0000_0200, 2,  0, 3, -1, -1, 0,  2, 0, 2, 1, 0, 3);
    vt[3]  = mk(1'b1, 32'h0000_0300, 3, -1, 0,  1, -1, 0,  2, 2, 0, 1, 1, 1);
    vt[4]  = mk(1'b0, 32'h0000_0400, 0, -1, 0, -1, -1, 0,  0, 0, 0, 1, 0, 0);
    vt[5]  = mk(1'b1, 32'hFFFF_FFFE, 2, -1, 0, -1, -1, 0,  2, 2, 0, 1, 0, 0);
    vt[6]  = mk(1'b0, 32'h0000_0500, 4, -1, 0, -1,  2, 0,  4, 0, 2, 0, 0, 0);
    vt[7]  = mk(1'b0, 32'h0000_0600, 3, -1, 0, -1, -1, 0,  3, 0, 3, 1, 0, 0);
    vt[8]  = mk(1'b1, 32'h0000_0700, 5, -1, 0, -1, -1, 1,  5, 5, 0, 1, 0, 0);
    vt[9]  = mk(1'b0, 32'h0000_0800, 2, -1, 0,  0, -1, 0,  1, 0, 0, 1, 1, 1);
    vt[10] = mk(1'b0, 32'h0000_0900, 3,  2, 2, -1, -1, 0,  3, 0, 3, 1, 0, 2);

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("reset_htrans", -1, 32'(bus.HTRANS), 32'(HTRANS_IDLE));
    chk("reset_haddr", -1, bus.HADDR, 32'h0);
    chk("reset_hwrite", -1, 32'(bus.HWRITE), 32'd0);
    chk("reset_hwdata", -1, bus.HWDATA, 32'h0);
    chk("reset_hsize", -1, 32'(bus.HSIZE), 32'(3'b010));
    chk("reset_hburst", -1, 32'(bus.HBURST), 32'(3'b000));
    chk("reset_cmd_ready", -1, 32'(bus.cmd_ready), 32'd1);
    chk("reset_wr_ready", -1, 32'(bus.wr_ready), 32'd0);
    chk("reset_rd_valid", -1, 32'(bus.rd_valid), 32'd0);
    chk("reset_rd_data", -1, bus.rd_data, 32'h0);
    chk("reset_done", -1, 32'(bus.done), 32'd0);
    chk("reset_err", -1, 32'(bus.err), 32'd0);
`ifdef MFP_AHB_MST_WAITCNT_EN
    chk("reset_wait_cnt", -1, 32'(wait_cnt), 32'd0);
`endif
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    for (int r = 0; r < NV; r++) run_vec(r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
